// File: rtl/core_run_ctrl.sv
// Run controller for a simulated core: sequences core reset, gates the core clock enable while
// running, and ends the run on a halt request, a PC self-loop or a cycle-budget timeout.
module core_run_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic [XLEN-1:0]  pc_in,
  output logic             core_rst_n,
  output logic             core_en,
  output logic             running,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [XLEN-1:0]  last_pc
);

  typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

  localparam logic [7:0]       RstLast  = 8'(RST_CYCLES - 1);
  // Counter value one short of the limit: the next unchanged cycle completes the self-loop.
  localparam logic [7:0]       StallPre = 8'(STALL_LIMIT - 2);
  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       rst_cnt_q, rst_cnt_d;
  logic [7:0]       stall_q, stall_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [1:0]       status_q, status_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             done_q, done_d;

  logic pc_changed, stall_hit, timeout_hit, clear_run;

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    stall_d       = stall_q;
    cycle_count_d = cycle_count_q;
    status_d      = status_q;
    last_pc_d     = last_pc_q;
    prev_pc_d     = prev_pc_q;
    pc_valid_d    = pc_valid_q;
    done_d        = done_q;
    clear_run     = 1'b0;

    // The first RUN cycle has no previous PC and always counts as a change.
    pc_changed  = !pc_valid_q || (pc_in != prev_pc_q);
    stall_hit   = !pc_changed && (stall_q == StallPre);
    timeout_hit = (cycle_count_q == CntLast);

    case (state_q)
      StIdle: begin
        if (start) clear_run = 1'b1;
      end
      StReset: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      StRun: begin
        cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
        prev_pc_d     = pc_in;
        pc_valid_d    = 1'b1;
        if (pc_changed) begin
          stall_d = '0;
        end else if (!(&stall_q)) begin
          stall_d = stall_q + 8'd1;
        end
        if (halt_req || stall_hit || timeout_hit) begin
          state_d   = StDone;
          done_d    = 1'b1;
          last_pc_d = pc_in;
          if (halt_req)       status_d = 2'b01;
          else if (stall_hit) status_d = 2'b10;
          else                status_d = 2'b11;
        end
      end
      StDone: begin
        if (start) clear_run = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (clear_run) begin
      state_d       = StReset;
      rst_cnt_d     = '0;
      stall_d       = '0;
      cycle_count_d = '0;
      status_d      = 2'b00;
      last_pc_d     = '0;
      pc_valid_d    = 1'b0;
      done_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      rst_cnt_q     <= '0;
      stall_q       <= '0;
      cycle_count_q <= '0;
      status_q      <= 2'b00;
      last_pc_q     <= '0;
      prev_pc_q     <= '0;
      pc_valid_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      stall_q       <= stall_d;
      cycle_count_q <= cycle_count_d;
      status_q      <= status_d;
      last_pc_q     <= last_pc_d;
      prev_pc_q     <= prev_pc_d;
      pc_valid_q    <= pc_valid_d;
      done_q        <= done_d;
    end
  end

  // Core stays out of reset in DONE so its state can still be inspected.
  assign core_rst_n  = (state_q == StRun) || (state_q == StDone);
  assign core_en     = (state_q == StRun);
  assign running     = (state_q == StRun);
  assign done        = done_q;
  assign status      = status_q;
  assign cycle_count = cycle_count_q;
  assign last_pc     = last_pc_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: one default instance and one with a 20-cycle budget,
// sharing clock, reset and stimulus.
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] pc_in = '0;

  logic        d_core_rst_n, d_core_en, d_running, d_done;
  logic [1:0]  d_status;
  logic [31:0] d_cycle_count, d_last_pc;
  logic        m_core_rst_n, m_core_en, m_running, m_done;
  logic [1:0]  m_status;
  logic [31:0] m_cycle_count, m_last_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_run_ctrl dut_d (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .pc_in      (pc_in),
    .core_rst_n (d_core_rst_n),
    .core_en    (d_core_en),
    .running    (d_running),
    .done       (d_done),
    .status     (d_status),
    .cycle_count(d_cycle_count),
    .last_pc    (d_last_pc)
  );

  core_run_ctrl #(.MAX_CYCLES(20)) dut_m (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .pc_in      (pc_in),
    .core_rst_n (m_core_rst_n),
    .core_en    (m_core_en),
    .running    (m_running),
    .done       (m_done),
    .status     (m_status),
    .cycle_count(m_cycle_count),
    .last_pc    (m_last_pc)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with core reset low, bounded so a stuck DUT cannot hang the run.
  task automatic wait_run(input bit sel, output int n);
    n = 0;
    while (((sel ? m_core_rst_n : d_core_rst_n) == 1'b0) && n < 10) begin
      n++;
      step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int k;

    // Reset values while rst is held low.
    #12;
    check_eq("rst_core_rst_n", d_core_rst_n, 0);
    check_eq("rst_core_en", d_core_en, 0);
    check_eq("rst_done", d_done, 0);
    check_eq("rst_status", d_status, 0);
    check_eq("rst_count", d_cycle_count, 0);
    check_eq("rst_last_pc", d_last_pc, 0);
    rst = 1'b1;
    step();
    step();
    check_eq("idle_core_rst_n", d_core_rst_n, 0);
    check_eq("idle_running", d_running, 0);

    // Halt on the 10th RUN cycle with an incrementing PC.
    pulse_start();
    wait_run(1'b0, n);
    check_eq("t1_rst_cycles", n, 2);
    check_eq("t1_running", d_running, 1);
    check_eq("t1_core_en", d_core_en, 1);
    for (k = 1; k <= 10; k++) begin
      pc_in    = 32'h100 + 32'(4 * k);
      halt_req = (k == 10);
      step();
    end
    halt_req = 1'b0;
    check_eq("t1_done", d_done, 1);
    check_eq("t1_status", d_status, 2'b01);
    check_eq("t1_count", d_cycle_count, 10);
    check_eq("t1_last_pc", d_last_pc, 32'h128);
    check_eq("t1_core_en", d_core_en, 0);
    check_eq("t1_core_rst_n", d_core_rst_n, 1);
    for (k = 0; k < 3; k++) begin
      pc_in    = 32'h900 + 32'(k);
      halt_req = 1'b1;
      step();
    end
    halt_req = 1'b0;
    check_eq("t1_hold_count", d_cycle_count, 10);
    check_eq("t1_hold_last_pc", d_last_pc, 32'h128);
    check_eq("t1_hold_status", d_status, 2'b01);

    // Relaunch from DONE; PC freezes at 0x40 from RUN cycle 5; start during RUN is ignored.
    pulse_start();
    check_eq("t2_clear_done", d_done, 0);
    check_eq("t2_clear_status", d_status, 0);
    check_eq("t2_clear_count", d_cycle_count, 0);
    check_eq("t2_clear_last_pc", d_last_pc, 0);
    wait_run(1'b0, n);
    check_eq("t2_rst_cycles", n, 2);
    for (k = 1; k <= 20; k++) begin
      pc_in = (k >= 5) ? 32'h40 : 32'h200 + 32'(4 * k);
      start = (k == 3);
      step();
      if (d_done) break;
    end
    start = 1'b0;
    check_eq("t2_end_cycle", k, 12);
    check_eq("t2_status", d_status, 2'b10);
    check_eq("t2_last_pc", d_last_pc, 32'h40);
    check_eq("t2_count", d_cycle_count, 12);

    // Timeout after 20 RUN cycles on the MAX_CYCLES=20 instance.
    pulse_start();
    wait_run(1'b1, n);
    check_eq("t3_rst_cycles", n, 2);
    for (k = 1; k <= 40; k++) begin
      pc_in = 32'h500 + 32'(4 * k);
      step();
      if (m_done) break;
    end
    check_eq("t3_end_cycle", k, 20);
    check_eq("t3_status", m_status, 2'b11);
    check_eq("t3_count", m_cycle_count, 20);
    check_eq("t3_core_en", m_core_en, 0);
    step();
    step();
    check_eq("t3_core_en_hold", m_core_en, 0);
    check_eq("t3_count_hold", m_cycle_count, 20);

    // Halt, self-loop and timeout all on cycle 20: halt wins; without halt, self-loop wins.
    for (int v = 0; v < 2; v++) begin
      pulse_start();
      wait_run(1'b1, n);
      for (k = 1; k <= 40; k++) begin
        pc_in    = (k >= 13) ? 32'h80 : 32'h300 + 32'(4 * k);
        halt_req = (v == 0) && (k == 20);
        step();
        if (m_done) break;
      end
      halt_req = 1'b0;
      check_eq("t4_end_cycle", k, 20);
      check_eq("t4_status", m_status, (v == 0) ? 2'b01 : 2'b10);
      check_eq("t4_count", m_cycle_count, 20);
    end

    // Asynchronous reset mid-RUN, away from a clock edge.
    pulse_start();
    wait_run(1'b1, n);
    for (k = 1; k <= 3; k++) begin
      pc_in = 32'h700 + 32'(4 * k);
      step();
    end
    #2;
    rst = 1'b0;
    #1;
    check_eq("t5_core_rst_n", m_core_rst_n, 0);
    check_eq("t5_core_en", m_core_en, 0);
    check_eq("t5_running", m_running, 0);
    check_eq("t5_done", m_done, 0);
    check_eq("t5_status", m_status, 0);
    check_eq("t5_count", m_cycle_count, 0);
    check_eq("t5_last_pc", m_last_pc, 0);
    #3;
    rst = 1'b1;
    step();
    step();
    check_eq("t5_idle_core_rst_n", m_core_rst_n, 0);
    check_eq("t5_idle_running", m_running, 0);
    pulse_start();
    wait_run(1'b1, n);
    check_eq("t5_rst_cycles", n, 2);
    pc_in    = 32'hABC;
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check_eq("t5_status_after", m_status, 2'b01);
    check_eq("t5_count_after", m_cycle_count, 1);
    check_eq("t5_last_pc_after", m_last_pc, 32'hABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
